lane_scatter_1to8: RTL and testbench

LANE_SCATTER_1TO8 -- requirements
Module: lane_scatter_1to8

---
 rtl/simd_pkg.sv | 13 +
 rtl/lane_reg_N.sv | 21 ++
 rtl/lane_scatter_1to8.sv | 94 +++++++++
 tb/tb_lane_scatter_1to8.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared SIMD definitions: lane count, lane index width
// and the scatter FSM state encoding.
package simd_pkg;

  localparam int LANES = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/lane_reg_N.sv
// One lane word: N-bit register with async active-high
// reset, load enable and hold.
module lane_reg_N #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lane_scatter_1to8.sv
// Serial-to-parallel scatter: fills 8 lanes one word per
// accept, then presents the vector until it is taken.
module lane_scatter_1to8
  import simd_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] I,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] O0,
  output logic [N-1:0] O1,
  output logic [N-1:0] O2,
  output logic [N-1:0] O3,
  output logic [N-1:0] O4,
  output logic [N-1:0] O5,
  output logic [N-1:0] O6,
  output logic [N-1:0] O7,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   S
);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] s_q;
  logic [IDX_W-1:0] s_d;
  logic             accept;
  logic             take;
  logic [N-1:0]     lane_q [LANES];

  assign in_ready  = en && (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready;
  assign take      = en && out_valid && out_ready;
  assign S         = s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  // FULL ignores in_valid, so a same-cycle take never bypasses
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          s_d = s_q + 1'b1;
          if (s_q == IDX_W'(LANES - 1)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (take) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_reg_N #(
      .N(N)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .load(accept && (s_q == IDX_W'(k))),
      .d   (I),
      .q   (lane_q[k])
    );
  end

  assign O0 = lane_q[0];
  assign O1 = lane_q[1];
  assign O2 = lane_q[2];
  assign O3 = lane_q[3];
  assign O4 = lane_q[4];
  assign O5 = lane_q[5];
  assign O6 = lane_q[6];
  assign O7 = lane_q[7];

endmodule

// File: tb/tb_lane_scatter_1to8.sv
// Directed bench for lane_scatter_1to8 (N=32) with
// hand-computed expectations.
module tb_lane_scatter_1to8;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] I;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   S;
  logic [N-1:0] o [8];

  int total;
  int bad;

  lane_scatter_1to8 #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .I        (I),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .O0       (O0),
    .O1       (O1),
    .O2       (O2),
    .O3       (O3),
    .O4       (O4),
    .O5       (O5),
    .O6       (O6),
    .O7       (O7),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S)
  );

  assign o[0] = O0;
  assign o[1] = O1;
  assign o[2] = O2;
  assign o[3] = O3;
  assign o[4] = O4;
  assign o[5] = O5;
  assign o[6] = O6;
  assign o[7] = O7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lanes_are(
    input string        tag,
    input logic [N-1:0] base
  );
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_o%0d", tag, k), o[k], base + N'(k));
    end
  endtask

  task automatic lanes_zero(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_o%0d", tag, k), o[k], '0);
    end
  endtask

  task automatic fill8(input logic [N-1:0] base);
    for (int k = 0; k < 8; k++) begin
      I        = base + N'(k);
      in_valid = 1'b1;
      step();
      if (k == 6) chk("pre8_vld", out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    en        = 1'b1;
    I         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    repeat (2) step();
    lanes_zero("rst");
    chk("rst_s", S, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    rst = 1'b0;

    // back-to-back fill
    fill8(32'h10);
    chk("fill_vld", out_valid, 1);
    chk("fill_rdy", in_ready, 0);
    chk("fill_s", S, 0);
    lanes_are("fill", 32'h10);

    // backpressure in FULL
    I        = 32'hDEADBEEF;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("bp_vld%0d", c), out_valid, 1);
      chk($sformatf("bp_o0_%0d", c), O0, 32'h10);
    end
    lanes_are("bp", 32'h10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("take_vld", out_valid, 0);
    chk("take_rdy", in_ready, 1);
    chk("take_o0", O0, 32'h10);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    I         = 32'h99;
    step();
    chk("next_o0", O0, 32'h99);
    chk("next_s", S, 1);
    chk("next_o1", O1, 32'h11);

    // two more accepts then freeze with en low
    I = 32'h91;
    step();
    I = 32'h92;
    step();
    chk("pre_frz_s", S, 3);
    en = 1'b0;
    I  = 32'hBAD;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("frz_s%0d", c), S, 3);
      chk($sformatf("frz_rdy%0d", c), in_ready, 0);
      chk($sformatf("frz_o3_%0d", c), O3, 32'h13);
    end
    chk("frz_o2", O2, 32'h92);
    en = 1'b1;
    I  = 32'h77;
    step();
    chk("unfrz_o3", O3, 32'h77);
    chk("unfrz_s", S, 4);
    I = 32'h78;
    step();
    chk("pre_rst_s", S, 5);
    in_valid = 1'b0;

    // async reset mid-cycle, mid-fill
    #3 rst = 1'b1;
    #1;
    chk("arst_s", S, 0);
    chk("arst_vld", out_valid, 0);
    chk("arst_rdy", in_ready, 1);
    lanes_zero("arst");
    rst = 1'b0;

    fill8(32'hA0);
    chk("refill_vld", out_valid, 1);
    lanes_are("refill", 32'hA0);

    // en low holds out_valid and ignores out_ready
    en        = 1'b0;
    out_ready = 1'b1;
    step();
    chk("en0_vld", out_valid, 1);
    chk("en0_rdy", in_ready, 0);
    en = 1'b1;

    // take and input in the same FULL cycle
    in_valid = 1'b1;
    I        = 32'h55;
    step();
    chk("sim_vld", out_valid, 0);
    chk("sim_o0", O0, 32'hA0);
    chk("sim_s", S, 0);
    chk("sim_rdy", in_ready, 1);
    out_ready = 1'b0;
    step();
    chk("sim_acc_o0", O0, 32'h55);
    chk("sim_acc_s", S, 1);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
